// File: rtl/mini_src_pkg.sv
// Shared Mini-SRC constants: opcodes, ALU add code, control states
// and instruction class indices used by the control unit.
package mini_src_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BRX  = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = OP_ADD;

    typedef enum logic [3:0] {
        RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALT
    } state_t;

    localparam int CL_ALU_R  = 0;
    localparam int CL_ALU_I  = 1;
    localparam int CL_UNARY  = 2;
    localparam int CL_LD     = 3;
    localparam int CL_LDI    = 4;
    localparam int CL_ST     = 5;
    localparam int CL_MULDIV = 6;
    localparam int CL_BRX    = 7;
    localparam int CL_JR     = 8;
    localparam int CL_JAL    = 9;
    localparam int CL_IN     = 10;
    localparam int CL_OUT    = 11;
    localparam int CL_MFHI   = 12;
    localparam int CL_MFLO   = 13;
    localparam int CL_NOP    = 14;
    localparam int CL_HALT   = 15;

endpackage

// File: rtl/control_unit_decode.sv
// Opcode to one-hot instruction class decode.
// MUL_DIV_EN: when undefined, mul/div decode as nop.
module instr_class_decode
    import mini_src_pkg::*;
(
    input  logic [4:0]  opcode,
    output logic [15:0] cls
);

    // One-hot class; unknown and reserved codes fall into nop
    always_comb begin
        cls = '0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA,
            OP_SHL, OP_ROR, OP_ROL:   cls[CL_ALU_R] = 1'b1;
            OP_ADDI, OP_ANDI, OP_ORI: cls[CL_ALU_I] = 1'b1;
            OP_NEG, OP_NOT:           cls[CL_UNARY] = 1'b1;
            OP_LD:                    cls[CL_LD]    = 1'b1;
            OP_LDI:                   cls[CL_LDI]   = 1'b1;
            OP_ST:                    cls[CL_ST]    = 1'b1;
`ifdef MUL_DIV_EN
            OP_MUL, OP_DIV:           cls[CL_MULDIV] = 1'b1;
`endif
            OP_BRX:                   cls[CL_BRX]   = 1'b1;
            OP_JR:                    cls[CL_JR]    = 1'b1;
            OP_JAL:                   cls[CL_JAL]   = 1'b1;
            OP_IN:                    cls[CL_IN]    = 1'b1;
            OP_OUT:                   cls[CL_OUT]   = 1'b1;
            OP_MFHI:                  cls[CL_MFHI]  = 1'b1;
            OP_MFLO:                  cls[CL_MFLO]  = 1'b1;
            OP_HALT:                  cls[CL_HALT]  = 1'b1;
            default:                  cls[CL_NOP]   = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control unit sequencing the Mini-SRC datapath.
// MUL_DIV_EN enables the mul/div execute sequences.
module control_unit
    import mini_src_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    input  logic        Stop,
    output logic        PCout, Zhighout, Zlowout, MDRout, HIout,
    output logic        LOout, InPortout, Cout, BAout,
    output logic        PCin, IRin, MARin, MDRin, Yin, Zhighin,
    output logic        Zlowin, HIin, LOin, OutPortin, CONin,
    output logic        Gra, Grb, Grc, Rin, Rout,
    output logic        IncPC, Read, Write, JAL_flag,
    output logic [4:0]  alu_op,
    output logic        Run
);

    localparam logic [15:0] LAST_T3 = (16'd1 << CL_JR) | (16'd1 << CL_IN)
        | (16'd1 << CL_OUT) | (16'd1 << CL_MFHI) | (16'd1 << CL_MFLO);
    localparam logic [15:0] LAST_T4 = (16'd1 << CL_UNARY) | (16'd1 << CL_JAL);
    localparam logic [15:0] LAST_T5 = (16'd1 << CL_ALU_R)
        | (16'd1 << CL_ALU_I) | (16'd1 << CL_LDI);
    localparam logic [15:0] LAST_T6 = (16'd1 << CL_MULDIV) | (16'd1 << CL_BRX);

    state_t      st, nxt;
    logic [15:0] cls;
    logic [4:0]  opcode;
    logic        last;
    logic        unused_ir;

    assign opcode    = IR[31:27];
    assign unused_ir = ^IR[26:0];

    instr_class_decode u_dec (
        .opcode (opcode),
        .cls    (cls)
    );

    // State register; clear forces RESET without waiting for a clock
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) st <= RESET;
        else        st <= nxt;
    end

    // Next state; Stop is only honoured on an instruction's final step
    always_comb begin
        nxt  = st;
        last = 1'b0;
        unique case (st)
            RESET: nxt = T0;
            T0:    nxt = T1;
            T1:    nxt = T2;
            T2: begin
                if (cls[CL_HALT])     nxt  = HALT;
                else if (cls[CL_NOP]) last = 1'b1;
                else                  nxt  = T3;
            end
            T3: begin nxt = T4; last = |(cls & LAST_T3); end
            T4: begin nxt = T5; last = |(cls & LAST_T4); end
            T5: begin nxt = T6; last = |(cls & LAST_T5); end
            T6: begin nxt = T7; last = |(cls & LAST_T6); end
            T7:    last = 1'b1;
            HALT:  nxt = HALT;
            default: nxt = RESET;
        endcase
        if (last) nxt = Stop ? HALT : T0;
    end

    // Strobe decode from present state and instruction class
    always_comb begin
        PCout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0;
        HIout = 1'b0; LOout = 1'b0; InPortout = 1'b0; Cout = 1'b0;
        BAout = 1'b0; PCin = 1'b0; IRin = 1'b0; MARin = 1'b0;
        MDRin = 1'b0; Yin = 1'b0; Zhighin = 1'b0; Zlowin = 1'b0;
        HIin = 1'b0; LOin = 1'b0; OutPortin = 1'b0; CONin = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
        IncPC = 1'b0; Read = 1'b0; Write = 1'b0; JAL_flag = 1'b0;
        alu_op = '0;
        Run = (st != RESET) && (st != HALT);
        unique case (st)
            T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; PCin = 1'b1; end
            T1: begin Read = 1'b1; MDRin = 1'b1; end
            T2: begin MDRout = 1'b1; IRin = 1'b1; end
            T3: begin
                if (cls[CL_ALU_R] | cls[CL_ALU_I]) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end
                if (cls[CL_UNARY]) begin
                    Grb = 1'b1; Rout = 1'b1; Zlowin = 1'b1; alu_op = opcode;
                end
                if (cls[CL_LDI] | cls[CL_LD] | cls[CL_ST]) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                end
                if (cls[CL_MULDIV]) begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                if (cls[CL_BRX])  begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                if (cls[CL_JR])   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                if (cls[CL_JAL])  begin PCout = 1'b1; JAL_flag = 1'b1; Rin = 1'b1; end
                if (cls[CL_IN])   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                if (cls[CL_OUT])  begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
                if (cls[CL_MFHI]) begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                if (cls[CL_MFLO]) begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            end
            T4: begin
                if (cls[CL_ALU_R]) begin
                    Grc = 1'b1; Rout = 1'b1; Zlowin = 1'b1; alu_op = opcode;
                end
                if (cls[CL_ALU_I]) begin Cout = 1'b1; Zlowin = 1'b1; alu_op = opcode; end
                if (cls[CL_UNARY]) begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                if (cls[CL_LDI] | cls[CL_LD] | cls[CL_ST]) begin
                    Cout = 1'b1; Zlowin = 1'b1; alu_op = ALU_ADD;
                end
                if (cls[CL_MULDIV]) begin
                    Grb = 1'b1; Rout = 1'b1; Zlowin = 1'b1; alu_op = opcode;
`ifdef MUL_DIV_EN
                    Zhighin = 1'b1;
`endif
                end
                if (cls[CL_BRX]) begin PCout = 1'b1; Yin = 1'b1; end
                if (cls[CL_JAL]) begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            end
            T5: begin
                if (cls[CL_ALU_R] | cls[CL_ALU_I] | cls[CL_LDI]) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end
                if (cls[CL_LD] | cls[CL_ST]) begin Zlowout = 1'b1; MARin = 1'b1; end
                if (cls[CL_MULDIV]) begin Zlowout = 1'b1; LOin = 1'b1; end
                if (cls[CL_BRX]) begin Cout = 1'b1; Zlowin = 1'b1; alu_op = ALU_ADD; end
            end
            T6: begin
                if (cls[CL_LD]) begin Read = 1'b1; MDRin = 1'b1; end
                if (cls[CL_ST]) begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
`ifdef MUL_DIV_EN
                if (cls[CL_MULDIV]) begin Zhighout = 1'b1; HIin = 1'b1; end
`endif
                if (cls[CL_BRX]) begin Zlowout = 1'b1; PCin = CON_FF; end
            end
            T7: begin
                if (cls[CL_LD]) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                if (cls[CL_ST]) Write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed testbench for control_unit.
// Define MUL_DIV_EN to match the RTL build when checking mul.
module tb_control_unit;

    typedef logic [34:0] vec_t;

    localparam vec_t PCOUT     = 35'd1 << 0;
    localparam vec_t ZHIGHOUT  = 35'd1 << 1;
    localparam vec_t ZLOWOUT   = 35'd1 << 2;
    localparam vec_t MDROUT    = 35'd1 << 3;
    localparam vec_t COUT      = 35'd1 << 7;
    localparam vec_t BAOUT     = 35'd1 << 8;
    localparam vec_t PCIN      = 35'd1 << 9;
    localparam vec_t IRIN      = 35'd1 << 10;
    localparam vec_t MARIN     = 35'd1 << 11;
    localparam vec_t MDRIN     = 35'd1 << 12;
    localparam vec_t YIN       = 35'd1 << 13;
    localparam vec_t ZHIGHIN   = 35'd1 << 14;
    localparam vec_t ZLOWIN    = 35'd1 << 15;
    localparam vec_t HIIN      = 35'd1 << 16;
    localparam vec_t LOIN      = 35'd1 << 17;
    localparam vec_t OUTPORTIN = 35'd1 << 18;
    localparam vec_t CONIN     = 35'd1 << 19;
    localparam vec_t GRA       = 35'd1 << 20;
    localparam vec_t GRB       = 35'd1 << 21;
    localparam vec_t GRC       = 35'd1 << 22;
    localparam vec_t RIN       = 35'd1 << 23;
    localparam vec_t ROUT      = 35'd1 << 24;
    localparam vec_t INCPC     = 35'd1 << 25;
    localparam vec_t READ      = 35'd1 << 26;
    localparam vec_t WRITE     = 35'd1 << 27;
    localparam vec_t JALF      = 35'd1 << 28;
    localparam vec_t RUN       = 35'd1 << 29;
    localparam vec_t OP_ADD_V  = vec_t'(5'b00011) << 30;
    localparam vec_t OP_MUL_V  = vec_t'(5'b01111) << 30;

    localparam vec_t E_T0 = PCOUT | MARIN | INCPC | PCIN | RUN;
    localparam vec_t E_T1 = READ | MDRIN | RUN;
    localparam vec_t E_T2 = MDROUT | IRIN | RUN;

    logic        clock, clear, CON_FF, Stop;
    logic [31:0] IR;
    logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout;
    logic        InPortout, Cout, BAout, PCin, IRin, MARin, MDRin;
    logic        Yin, Zhighin, Zlowin, HIin, LOin, OutPortin, CONin;
    logic        Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write, JAL_flag;
    logic [4:0]  alu_op;
    logic        Run;
    vec_t        obs;
    int          nchk, nerr;

    control_unit dut (
        .clock(clock), .clear(clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .MDRout(MDRout), .HIout(HIout), .LOout(LOout),
        .InPortout(InPortout), .Cout(Cout), .BAout(BAout),
        .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin),
        .Yin(Yin), .Zhighin(Zhighin), .Zlowin(Zlowin), .HIin(HIin),
        .LOin(LOin), .OutPortin(OutPortin), .CONin(CONin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .IncPC(IncPC), .Read(Read), .Write(Write), .JAL_flag(JAL_flag),
        .alu_op(alu_op), .Run(Run)
    );

    assign obs = {alu_op, Run, JAL_flag, Write, Read, IncPC, Rout, Rin,
                  Grc, Grb, Gra, CONin, OutPortin, LOin, HIin, Zlowin,
                  Zhighin, Yin, MDRin, MARin, IRin, PCin, BAout, Cout,
                  InPortout, LOout, HIout, MDRout, Zlowout, Zhighout, PCout};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input vec_t got, input vec_t exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    // Checks T0..T2 starting from a sampled T0, ends sampled in T3
    task automatic fetch(input string tag, input logic [31:0] ir);
        IR = ir;
        chk({tag, "_t0"}, obs, E_T0); step;
        chk({tag, "_t1"}, obs, E_T1); step;
        chk({tag, "_t2"}, obs, E_T2); step;
    endtask

    initial begin
        nchk = 0; nerr = 0;
        clear = 1'b0; Stop = 1'b0; CON_FF = 1'b0; IR = '0;
        #1;
        repeat (3) begin
            step;
            chk("reset", obs, '0);
        end
        clear = 1'b1;
        step;

        // add R1,R2,R3
        fetch("add", 32'h18918000);
        chk("add_t3", obs, GRB | ROUT | YIN | RUN); step;
        chk("add_t4", obs, GRC | ROUT | ZLOWIN | RUN | OP_ADD_V); step;
        chk("add_t5", obs, ZLOWOUT | GRA | RIN | RUN); step;

        // out R3
        fetch("out", 32'hB9800000);
        chk("out_t3", obs, GRA | ROUT | OUTPORTIN | RUN); step;

        // jal
        fetch("jal", 32'hA8000000);
        chk("jal_t3", obs, PCOUT | JALF | RIN | RUN); step;
        chk("jal_t4", obs, GRA | ROUT | PCIN | RUN); step;

        // brx, not taken then taken
        for (int k = 0; k < 2; k++) begin
            CON_FF = k[0];
            fetch("brx", 32'h98000000);
            chk("brx_t3", obs, GRA | ROUT | CONIN | RUN); step;
            chk("brx_t4", obs, PCOUT | YIN | RUN); step;
            chk("brx_t5", obs, COUT | ZLOWIN | RUN | OP_ADD_V); step;
            chk(k == 0 ? "brx_t6_nt" : "brx_t6_tk", obs,
                ZLOWOUT | RUN | (k == 0 ? vec_t'(0) : PCIN));
            step;
        end
        CON_FF = 1'b0;

        // mul
        fetch("mul", 32'h78000000);
`ifdef MUL_DIV_EN
        chk("mul_t3", obs, GRA | ROUT | YIN | RUN); step;
        chk("mul_t4", obs, GRB | ROUT | ZHIGHIN | ZLOWIN | RUN | OP_MUL_V); step;
        chk("mul_t5", obs, ZLOWOUT | LOIN | RUN); step;
        chk("mul_t6", obs, ZHIGHOUT | HIIN | RUN); step;
`endif
        chk("mul_next", obs, E_T0);

        // nop and reserved opcode
        fetch("nop", 32'hD0000000);
        fetch("rsv", 32'hF8000000);

        // ld, full 8 cycles
        fetch("ld", 32'h00000000);
        chk("ld_t3", obs, GRB | BAOUT | YIN | RUN); step;
        chk("ld_t4", obs, COUT | ZLOWIN | RUN | OP_ADD_V); step;
        chk("ld_t5", obs, ZLOWOUT | MARIN | RUN); step;
        chk("ld_t6", obs, READ | MDRIN | RUN); step;
        chk("ld_t7", obs, MDROUT | GRA | RIN | RUN); step;

        // st, abandoned by reset in T4
        fetch("st", 32'h10000000);
        chk("st_t3", obs, GRB | BAOUT | YIN | RUN); step;
        chk("st_t4", obs, COUT | ZLOWIN | RUN | OP_ADD_V);
        clear = 1'b0;
        #1;
        chk("rst_async", obs, '0);
        step;
        chk("rst_hold", obs, '0);
        clear = 1'b1;
        step;
        chk("rst_t0", obs, E_T0);

        // Stop raised early still lets add finish, then halts
        Stop = 1'b1;
        fetch("stp", 32'h18918000);
        chk("stp_t3", obs, GRB | ROUT | YIN | RUN); step;
        chk("stp_t4", obs, GRC | ROUT | ZLOWIN | RUN | OP_ADD_V); step;
        chk("stp_t5", obs, ZLOWOUT | GRA | RIN | RUN); step;
        Stop = 1'b0;
        chk("stp_halt", obs, '0);
        clear = 1'b0;
        step;
        clear = 1'b1;
        step;

        // halt opcode
        fetch("hlt", 32'hD8000000);
        for (int c = 0; c < 10; c++) begin
            chk("hlt_idle", obs, '0);
            step;
        end
        clear = 1'b0;
        step;
        clear = 1'b1;
        step;
        chk("hlt_restart", obs, E_T0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
